// File: rtl/uart_spi_bridge.sv
// UART <-> SPI-slave bridge. Bytes received on the UART are queued for the SPI
// master to read on miso; words written by the SPI master on mosi are queued
// for transmission on the UART. Everything runs on one clock, and every
// external pin is brought in through a 2-flop synchroniser.
module uart_spi_bridge #(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    freq_control,
    input  logic                          uart_rx_d_in,
    output logic                          uart_tx_d_out,
    input  logic                          cs_bar,
    input  logic                          sclk,
    input  logic                          mosi,
    output logic                          miso,
    output logic                          uart_rx_valid,
    output logic                          spi_rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   u2s_count,
    output logic [$clog2(FIFO_DEPTH):0]   s2u_count,
    output logic                          overflow,
    output logic                          frame_err,
    input  logic                          clear_err
);

    localparam int PW       = $clog2(FIFO_DEPTH);
    localparam int CW       = PW + 1;
    localparam int PERIOD_W = $clog2(CLKS_PER_BIT * 8) + 1;
    localparam int BC_W     = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // ---------------------------------------------------------------- synchronisers
    logic r_rx_s1, r_rx_s2, r_rx_q;
    logic r_cs_s1, r_cs_s2, r_cs_q;
    logic r_sclk_s1, r_sclk_s2, r_sclk_q;
    logic r_mosi_s1, r_mosi_s2;

    // Two-flop synchronisers plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            {r_rx_s1, r_rx_s2, r_rx_q}       <= 3'b111;
            {r_cs_s1, r_cs_s2, r_cs_q}       <= 3'b111;
            {r_sclk_s1, r_sclk_s2, r_sclk_q} <= 3'b000;
            {r_mosi_s1, r_mosi_s2}           <= 2'b00;
        end else begin
            {r_rx_s1, r_rx_s2, r_rx_q}       <= {uart_rx_d_in, r_rx_s1, r_rx_s2};
            {r_cs_s1, r_cs_s2, r_cs_q}       <= {cs_bar, r_cs_s1, r_cs_s2};
            {r_sclk_s1, r_sclk_s2, r_sclk_q} <= {sclk, r_sclk_s1, r_sclk_s2};
            {r_mosi_s1, r_mosi_s2}           <= {mosi, r_mosi_s1};
        end
    end

    logic w_rx_fall, w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;
    assign w_rx_fall   = r_rx_q & ~r_rx_s2;
    assign w_cs_fall   = r_cs_q & ~r_cs_s2;
    assign w_cs_rise   = ~r_cs_q & r_cs_s2;
    assign w_sclk_rise = ~r_sclk_q & r_sclk_s2;
    assign w_sclk_fall = r_sclk_q & ~r_sclk_s2;

    logic [PERIOD_W-1:0] w_period_sel;
    assign w_period_sel = PERIOD_W'(CLKS_PER_BIT) << freq_control;

    // ---------------------------------------------------------------- FIFO wiring
    logic [DATA_W-1:0] r_u2s_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_u2s_wr, r_u2s_rd;
    logic [CW-1:0]     r_u2s_cnt;
    logic [DATA_W-1:0] r_s2u_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_s2u_wr, r_s2u_rd;
    logic [CW-1:0]     r_s2u_cnt;

    logic w_u2s_push, w_u2s_pop, w_u2s_full, w_u2s_avail, w_u2s_wr_en;
    logic w_s2u_push, w_s2u_pop, w_s2u_full, w_s2u_avail, w_s2u_wr_en;
    logic [DATA_W-1:0] w_s2u_wdata;

    assign w_u2s_full  = (r_u2s_cnt == CW'(FIFO_DEPTH));
    assign w_u2s_avail = (r_u2s_cnt != '0);
    assign w_s2u_full  = (r_s2u_cnt == CW'(FIFO_DEPTH));
    assign w_s2u_avail = (r_s2u_cnt != '0);
    // A push into a full FIFO still lands if the same cycle frees a slot.
    assign w_u2s_wr_en = w_u2s_push & (~w_u2s_full | w_u2s_pop);
    assign w_s2u_wr_en = w_s2u_push & (~w_s2u_full | w_s2u_pop);

    // ---------------------------------------------------------------- UART RX
    state_e              r_rx_state;
    logic [PERIOD_W-1:0] r_rx_cnt, r_rx_period;
    logic [BC_W-1:0]     r_rx_bits;
    logic [DATA_W-1:0]   r_rx_shift;
    logic                r_rx_valid;
    logic                w_rx_half, w_rx_tick, w_rx_ferr;

    assign w_rx_half  = (r_rx_cnt == (r_rx_period >> 1) - PERIOD_W'(1));
    assign w_rx_tick  = (r_rx_cnt == r_rx_period - PERIOD_W'(1));
    assign w_u2s_push = (r_rx_state == StStop) & w_rx_tick & r_rx_s2;
    assign w_rx_ferr  = (r_rx_state == StStop) & w_rx_tick & ~r_rx_s2;

    // Receive FSM: mid-bit sampling, start-bit glitch rejection, LSB first.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state  <= StIdle;
            r_rx_cnt    <= '0;
            r_rx_period <= PERIOD_W'(CLKS_PER_BIT);
            r_rx_bits   <= '0;
            r_rx_shift  <= '0;
            r_rx_valid  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_rx_state)
                StIdle: begin
                    if (w_rx_fall) begin
                        r_rx_state  <= StStart;
                        r_rx_cnt    <= '0;
                        r_rx_period <= w_period_sel;
                    end
                end
                StStart: begin
                    if (w_rx_half) begin
                        r_rx_cnt   <= '0;
                        r_rx_bits  <= '0;
                        r_rx_state <= r_rx_s2 ? StIdle : StData;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + PERIOD_W'(1);
                    end
                end
                StData: begin
                    if (w_rx_tick) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_W-1:1]};
                        r_rx_bits  <= r_rx_bits + BC_W'(1);
                        if (r_rx_bits == BC_W'(DATA_W - 1)) r_rx_state <= StStop;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + PERIOD_W'(1);
                    end
                end
                StStop: begin
                    if (w_rx_tick) begin
                        r_rx_state <= StIdle;
                        r_rx_valid <= r_rx_s2;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + PERIOD_W'(1);
                    end
                end
                default: r_rx_state <= StIdle;
            endcase
        end
    end

    // ---------------------------------------------------------------- UART TX
    state_e              r_tx_state;
    logic [PERIOD_W-1:0] r_tx_cnt, r_tx_period;
    logic [BC_W-1:0]     r_tx_bits;
    logic [DATA_W-1:0]   r_tx_shift;
    logic                r_tx_out;
    logic                w_tx_tick;

    assign w_tx_tick = (r_tx_cnt == r_tx_period - PERIOD_W'(1));
    // A new frame may start from idle or directly as the stop bit ends.
    assign w_s2u_pop = ((r_tx_state == StIdle) | ((r_tx_state == StStop) & w_tx_tick))
                       & w_s2u_avail;

    // Transmit FSM: start bit, DATA_W bits LSB first, stop bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state  <= StIdle;
            r_tx_cnt    <= '0;
            r_tx_period <= PERIOD_W'(CLKS_PER_BIT);
            r_tx_bits   <= '0;
            r_tx_shift  <= '0;
            r_tx_out    <= 1'b1;
        end else if (w_s2u_pop) begin
            r_tx_state  <= StStart;
            r_tx_cnt    <= '0;
            r_tx_period <= w_period_sel;
            r_tx_shift  <= r_s2u_mem[r_s2u_rd];
            r_tx_out    <= 1'b0;
        end else begin
            case (r_tx_state)
                StIdle: r_tx_out <= 1'b1;
                StStart: begin
                    if (w_tx_tick) begin
                        r_tx_cnt   <= '0;
                        r_tx_bits  <= '0;
                        r_tx_out   <= r_tx_shift[0];
                        r_tx_state <= StData;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + PERIOD_W'(1);
                    end
                end
                StData: begin
                    if (w_tx_tick) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bits == BC_W'(DATA_W - 1)) begin
                            r_tx_out   <= 1'b1;
                            r_tx_state <= StStop;
                        end else begin
                            r_tx_out   <= r_tx_shift[1];
                            r_tx_shift <= {1'b0, r_tx_shift[DATA_W-1:1]};
                            r_tx_bits  <= r_tx_bits + BC_W'(1);
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + PERIOD_W'(1);
                    end
                end
                StStop: begin
                    if (w_tx_tick) r_tx_state <= StIdle;
                    else           r_tx_cnt   <= r_tx_cnt + PERIOD_W'(1);
                end
                default: r_tx_state <= StIdle;
            endcase
        end
    end

    // ---------------------------------------------------------------- SPI slave
    logic [DATA_W-1:0] r_spi_rx, r_spi_tx;
    logic [BC_W-1:0]   r_spi_bits;
    logic              r_spi_reload, r_spi_valid;
    logic              w_spi_active, w_spi_load;

    assign w_spi_active = ~r_cs_s2;
    // Load on select, and again on the falling edge after each completed word.
    assign w_spi_load   = w_cs_fall | (w_spi_active & w_sclk_fall & r_spi_reload);
    assign w_u2s_pop    = w_spi_load & w_u2s_avail;
    assign w_s2u_push   = w_spi_active & w_sclk_rise & (r_spi_bits == BC_W'(DATA_W - 1));
    assign w_s2u_wdata  = {r_spi_rx[DATA_W-2:0], r_mosi_s2};

    // Mode-0 shifter: capture mosi on rising sclk, advance miso on falling sclk.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_spi_rx     <= '0;
            r_spi_tx     <= '0;
            r_spi_bits   <= '0;
            r_spi_reload <= 1'b0;
            r_spi_valid  <= 1'b0;
        end else begin
            r_spi_valid <= 1'b0;
            if (w_cs_rise) begin
                // Deselect drops any partial word.
                r_spi_bits   <= '0;
                r_spi_reload <= 1'b0;
            end else if (w_spi_active) begin
                if (w_cs_fall) r_spi_bits <= '0;
                if (w_sclk_rise) begin
                    r_spi_rx <= w_s2u_wdata;
                    if (w_s2u_push) begin
                        r_spi_bits   <= '0;
                        r_spi_reload <= 1'b1;
                        r_spi_valid  <= 1'b1;
                    end else begin
                        r_spi_bits <= r_spi_bits + BC_W'(1);
                    end
                end
                if (w_spi_load) begin
                    r_spi_tx     <= w_u2s_avail ? r_u2s_mem[r_u2s_rd] : '0;
                    r_spi_reload <= 1'b0;
                end else if (w_sclk_fall) begin
                    r_spi_tx <= {r_spi_tx[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    // ---------------------------------------------------------------- FIFO state
    // Storage arrays; writes are gated off during reset so nothing partial lands.
    always_ff @(posedge clk) begin
        if (!reset && w_u2s_wr_en) r_u2s_mem[r_u2s_wr] <= r_rx_shift;
        if (!reset && w_s2u_wr_en) r_s2u_mem[r_s2u_wr] <= w_s2u_wdata;
    end

    // Pointer and occupancy tracking for both FIFOs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_u2s_wr  <= '0;
            r_u2s_rd  <= '0;
            r_u2s_cnt <= '0;
            r_s2u_wr  <= '0;
            r_s2u_rd  <= '0;
            r_s2u_cnt <= '0;
        end else begin
            if (w_u2s_wr_en) r_u2s_wr <= r_u2s_wr + PW'(1);
            if (w_u2s_pop)   r_u2s_rd <= r_u2s_rd + PW'(1);
            r_u2s_cnt <= r_u2s_cnt + CW'(w_u2s_wr_en) - CW'(w_u2s_pop);
            if (w_s2u_wr_en) r_s2u_wr <= r_s2u_wr + PW'(1);
            if (w_s2u_pop)   r_s2u_rd <= r_s2u_rd + PW'(1);
            r_s2u_cnt <= r_s2u_cnt + CW'(w_s2u_wr_en) - CW'(w_s2u_pop);
        end
    end

    // ---------------------------------------------------------------- error flags
    logic r_overflow, r_frame_err;
    logic w_ovf_set;
    assign w_ovf_set = (w_u2s_push & ~w_u2s_wr_en) | (w_s2u_push & ~w_s2u_wr_en);

    // Sticky error flags; clear_err wins over a same-cycle set.
    always_ff @(posedge clk) begin
        if (reset || clear_err) begin
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overflow  <= r_overflow | w_ovf_set;
            r_frame_err <= r_frame_err | w_rx_ferr;
        end
    end

    assign uart_tx_d_out = r_tx_out;
    assign miso          = w_spi_active & r_spi_tx[DATA_W-1];
    assign uart_rx_valid = r_rx_valid;
    assign spi_rx_valid  = r_spi_valid;
    assign u2s_count     = r_u2s_cnt;
    assign s2u_count     = r_s2u_cnt;
    assign overflow      = r_overflow;
    assign frame_err     = r_frame_err;

endmodule

// File: tb/tb_uart_spi_bridge.sv
// Self-checking bench for uart_spi_bridge: directed scenarios plus randomized
// UART/SPI traffic checked against queue-based FIFO models.
module tb_uart_spi_bridge;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CPB   = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    freq_control = 2'd0;
    logic          uart_rx_d_in = 1'b1;
    logic          uart_tx_d_out;
    logic          cs_bar = 1'b1;
    logic          sclk = 1'b0;
    logic          mosi = 1'b0;
    logic          miso;
    logic          uart_rx_valid, spi_rx_valid;
    logic [CW-1:0] u2s_count, s2u_count;
    logic          overflow, frame_err;
    logic          clear_err = 1'b0;

    always #5 clk = ~clk;

    uart_spi_bridge #(
        .DATA_W       (DW),
        .FIFO_DEPTH   (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .freq_control  (freq_control),
        .uart_rx_d_in  (uart_rx_d_in),
        .uart_tx_d_out (uart_tx_d_out),
        .cs_bar        (cs_bar),
        .sclk          (sclk),
        .mosi          (mosi),
        .miso          (miso),
        .uart_rx_valid (uart_rx_valid),
        .spi_rx_valid  (spi_rx_valid),
        .u2s_count     (u2s_count),
        .s2u_count     (s2u_count),
        .overflow      (overflow),
        .frame_err     (frame_err),
        .clear_err     (clear_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int rx_pulses  = 0;
    int spi_pulses = 0;

    // Reference model: FIFO contents and expected pulse counts.
    logic [DW-1:0] u2s_q [$];
    int exp_rx_pulses  = 0;
    int exp_spi_pulses = 0;

    always @(posedge clk) begin
        if (uart_rx_valid) rx_pulses  <= rx_pulses + 1;
        if (spi_rx_valid)  spi_pulses <= spi_pulses + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] make_frame(input logic [DW-1:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    // Drive one UART frame; freq_control is scrambled mid-frame to prove it is latched.
    task automatic uart_send(input logic [DW-1:0] d, input logic stop_bit, input logic [1:0] fc);
        int p;
        p = CPB << fc;
        freq_control = fc;
        wait_clks(2);
        uart_rx_d_in = 1'b0;
        wait_clks(p / 2);
        freq_control = 2'($urandom_range(0, 3));
        wait_clks(p - p / 2);
        for (int i = 0; i < DW; i++) begin
            uart_rx_d_in = d[i];
            wait_clks(p);
        end
        uart_rx_d_in = stop_bit;
        wait_clks(p);
        uart_rx_d_in = 1'b1;
        freq_control = fc;
        wait_clks(p);
        if (stop_bit) begin
            exp_rx_pulses++;
            if (u2s_q.size() < DEPTH) u2s_q.push_back(d);
        end
    endtask

    // Mode-0 master: nbits clocks, 8 clk per half period; returns bits seen on miso.
    task automatic spi_xfer(input logic [DW-1:0] mo, input int nbits, output logic [DW-1:0] mi);
        mi = '0;
        cs_bar = 1'b0;
        wait_clks(8);
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[DW-1-i];
            wait_clks(8);
            mi = {mi[DW-2:0], miso};
            sclk = 1'b1;
            wait_clks(8);
            sclk = 1'b0;
        end
        mosi = 1'b0;
        wait_clks(8);
        cs_bar = 1'b1;
        wait_clks(8);
    endtask

    // Model of the slave side: select pops one word (or 0), a full word pops one more.
    function automatic logic [DW-1:0] model_spi(input int nbits);
        logic [DW-1:0] first;
        first = (u2s_q.size() != 0) ? u2s_q.pop_front() : '0;
        if (nbits == DW) begin
            exp_spi_pulses++;
            if (u2s_q.size() != 0) void'(u2s_q.pop_front());
        end
        return first;
    endfunction

    // Wait for a start bit (bounded) then sample 10 bits mid-bit, start bit first.
    task automatic uart_capture(input logic [1:0] fc, output logic [9:0] frame);
        int p;
        int n;
        p = CPB << fc;
        n = 0;
        frame = '0;
        while (uart_tx_d_out !== 1'b0 && n < 3000) begin
            wait_clks(1);
            n++;
        end
        if (n >= 3000) begin
            check_eq("tx_start_timeout", 32'(uart_tx_d_out), 32'd0);
        end else begin
            wait_clks(p / 2);
            frame[0] = uart_tx_d_out;
            for (int k = 1; k < 10; k++) begin
                wait_clks(p);
                frame[k] = uart_tx_d_out;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_clks(3);
        reset = 1'b0;
        u2s_q.delete();
        wait_clks(1);
    endtask

    task automatic xfer_and_capture(input logic [DW-1:0] mo, input logic [1:0] fc,
                                    output logic [DW-1:0] mi, output logic [9:0] frame);
        freq_control = fc;
        fork
            spi_xfer(mo, DW, mi);
            uart_capture(fc, frame);
        join
    endtask

    initial begin
        logic [DW-1:0] mi, exp_mi, w;
        logic [9:0]    fr;
        logic [DW-1:0] words [5];
        logic [1:0]    fc;
        int            nw, lows;

        // Reset state
        do_reset();
        check_eq("rst_tx_out", 32'(uart_tx_d_out), 32'd1);
        check_eq("rst_miso", 32'(miso), 32'd0);
        check_eq("rst_u2s_count", 32'(u2s_count), 32'd0);
        check_eq("rst_s2u_count", 32'(s2u_count), 32'd0);
        check_eq("rst_flags", 32'({overflow, frame_err, uart_rx_valid, spi_rx_valid}), 32'd0);

        // UART 0xA5 -> SPI miso 10100101
        uart_send(8'hA5, 1'b1, 2'd0);
        check_eq("a5_rx_pulse", 32'(rx_pulses), 32'(exp_rx_pulses));
        check_eq("a5_u2s_count", 32'(u2s_count), 32'd1);
        w = 8'($urandom);
        exp_mi = model_spi(DW);
        xfer_and_capture(w, 2'd0, mi, fr);
        check_eq("a5_miso", 32'(mi), 32'h0000_00A5);
        check_eq("a5_miso_model", 32'(mi), 32'(exp_mi));
        check_eq("a5_tx_frame", 32'(fr), 32'(make_frame(w)));
        check_eq("a5_u2s_empty", 32'(u2s_count), 32'd0);

        // SPI 0x3C -> UART frame 0,0,0,1,1,1,1,0,0,1
        exp_mi = model_spi(DW);
        xfer_and_capture(8'h3C, 2'd0, mi, fr);
        check_eq("3c_spi_pulses", 32'(spi_pulses), 32'(exp_spi_pulses));
        check_eq("3c_tx_frame", 32'(fr), 32'(10'b1001111000));
        check_eq("3c_miso_empty", 32'(mi), 32'(exp_mi));

        // Randomized round trips at varying rates
        for (int it = 0; it < 6; it++) begin
            fc = 2'($urandom_range(0, 2));
            nw = $urandom_range(1, 2);
            for (int j = 0; j < nw; j++) uart_send(8'($urandom), 1'b1, fc);
            check_eq("rnd_u2s_count", 32'(u2s_count), 32'(u2s_q.size()));
            check_eq("rnd_rx_pulses", 32'(rx_pulses), 32'(exp_rx_pulses));
            w = 8'($urandom);
            exp_mi = model_spi(DW);
            xfer_and_capture(w, fc, mi, fr);
            check_eq("rnd_miso", 32'(mi), 32'(exp_mi));
            check_eq("rnd_tx_frame", 32'(fr), 32'(make_frame(w)));
            check_eq("rnd_u2s_after", 32'(u2s_count), 32'(u2s_q.size()));
        end
        wait_clks(200);
        check_eq("rnd_s2u_drained", 32'(s2u_count), 32'd0);
        check_eq("rnd_spi_pulses", 32'(spi_pulses), 32'(exp_spi_pulses));

        // Overflow: five words into a four-deep FIFO
        do_reset();
        exp_rx_pulses = rx_pulses;
        for (int j = 0; j < 5; j++) begin
            words[j] = 8'($urandom);
            uart_send(words[j], 1'b1, 2'd0);
        end
        check_eq("ovf_u2s_count", 32'(u2s_count), 32'd4);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        check_eq("ovf_rx_pulses", 32'(rx_pulses), 32'(exp_rx_pulses));
        clear_err = 1'b1;
        wait_clks(1);
        clear_err = 1'b0;
        check_eq("ovf_cleared", 32'(overflow), 32'd0);
        exp_mi = model_spi(DW);
        spi_xfer(8'($urandom), DW, mi);
        check_eq("ovf_drain0", 32'(mi), 32'(words[0]));
        check_eq("ovf_drain0_model", 32'(mi), 32'(exp_mi));
        exp_mi = model_spi(DW);
        spi_xfer(8'($urandom), DW, mi);
        check_eq("ovf_drain2", 32'(mi), 32'(words[2]));
        check_eq("ovf_u2s_empty", 32'(u2s_count), 32'd0);

        // Framing error and glitch rejection
        do_reset();
        exp_rx_pulses = rx_pulses;
        uart_send(8'($urandom), 1'b0, 2'd0);
        check_eq("ferr_flag", 32'(frame_err), 32'd1);
        check_eq("ferr_no_push", 32'(u2s_count), 32'd0);
        check_eq("ferr_no_pulse", 32'(rx_pulses), 32'(exp_rx_pulses));
        clear_err = 1'b1;
        wait_clks(1);
        clear_err = 1'b0;
        check_eq("ferr_cleared", 32'(frame_err), 32'd0);
        uart_rx_d_in = 1'b0;
        wait_clks(3);
        uart_rx_d_in = 1'b1;
        wait_clks(200);
        check_eq("glitch_no_pulse", 32'(rx_pulses), 32'(exp_rx_pulses));
        check_eq("glitch_no_ferr", 32'(frame_err), 32'd0);
        check_eq("glitch_no_push", 32'(u2s_count), 32'd0);
        w = 8'($urandom);
        uart_send(w, 1'b1, 2'd1);
        check_eq("post_glitch_push", 32'(u2s_count), 32'd1);
        exp_mi = model_spi(DW);
        xfer_and_capture(8'($urandom), 2'd1, mi, fr);
        check_eq("post_glitch_miso", 32'(mi), 32'(w));

        // Aborted transfer then full transfer with empty u2s FIFO
        wait_clks(200);
        exp_spi_pulses = spi_pulses;
        spi_xfer(8'($urandom), 5, mi);
        check_eq("abort_s2u_count", 32'(s2u_count), 32'd0);
        check_eq("abort_no_pulse", 32'(spi_pulses), 32'(exp_spi_pulses));
        w = 8'($urandom);
        exp_mi = model_spi(DW);
        xfer_and_capture(w, 2'd0, mi, fr);
        check_eq("empty_miso_zero", 32'(mi), 32'd0);
        check_eq("after_abort_frame", 32'(fr), 32'(make_frame(w)));
        check_eq("after_abort_pulse", 32'(spi_pulses), 32'(exp_spi_pulses));

        // Reset in the middle of a UART TX frame
        wait_clks(200);
        freq_control = 2'd0;
        spi_xfer(8'h00, DW, mi);
        wait_clks(40);
        reset = 1'b1;
        wait_clks(1);
        reset = 1'b0;
        check_eq("midrst_tx_out", 32'(uart_tx_d_out), 32'd1);
        check_eq("midrst_counts", 32'({u2s_count, s2u_count}), 32'd0);
        lows = 0;
        for (int k = 0; k < 200; k++) begin
            if (uart_tx_d_out === 1'b0) lows++;
            wait_clks(1);
        end
        check_eq("midrst_tx_idle", 32'(lows), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
